// File: rtl/cache_mem_arbiter_pkg.sv
// Shared cache definitions: arbiter FSM states and the cache-line read type code.
package cache_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_e;

  localparam logic [2:0] RD_TYPE_LINE = 3'b100;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache and dcache read ports onto one bridge read port, one read outstanding,
// data-first priority with a bounded wait for instruction fetches.
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        i_rd_req,
  input  logic [2:0]  i_rd_type,
  input  logic [31:0] i_rd_addr,
  output logic        i_rd_rdy,
  output logic        i_ret_valid,
  output logic        i_ret_last,
  output logic [31:0] i_ret_data,

  input  logic        d_rd_req,
  input  logic [2:0]  d_rd_type,
  input  logic [31:0] d_rd_addr,
  output logic        d_rd_rdy,
  output logic        d_ret_valid,
  output logic        d_ret_last,
  output logic [31:0] d_ret_data,

  output logic        m_rd_req,
  output logic [2:0]  m_rd_type,
  output logic [31:0] m_rd_addr,
  input  logic        m_rd_rdy,
  input  logic        m_ret_valid,
  input  logic        m_ret_last,
  input  logic [31:0] m_ret_data
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_e state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       inst_win;
  logic       req_any;
  logic       grant;

  assign i_ret_data = m_ret_data;
  assign d_ret_data = m_ret_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    // Data wins ties unless the icache has already watched LIMIT data grants go by.
    inst_win    = i_rd_req & (~d_rd_req | (starve_q == LIMIT));
    req_any     = i_rd_req | d_rd_req;
    grant       = 1'b0;
    state_d     = state_q;
    starve_d    = starve_q;
    m_rd_req    = 1'b0;
    m_rd_type   = inst_win ? i_rd_type : d_rd_type;
    m_rd_addr   = inst_win ? i_rd_addr : d_rd_addr;
    i_rd_rdy    = 1'b0;
    d_rd_rdy    = 1'b0;
    i_ret_valid = 1'b0;
    i_ret_last  = 1'b0;
    d_ret_valid = 1'b0;
    d_ret_last  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        m_rd_req = req_any;
        grant    = req_any & m_rd_rdy;
        i_rd_rdy = inst_win & m_rd_rdy;
        d_rd_rdy = d_rd_req & ~inst_win & m_rd_rdy;
        if (!i_rd_req) starve_d = 4'd0;
        if (grant) begin
          if (inst_win) begin
            state_d  = ST_BUSY_I;
            starve_d = 4'd0;
          end else begin
            state_d = ST_BUSY_D;
            if (i_rd_req && (starve_q != LIMIT)) starve_d = starve_q + 4'd1;
          end
        end
      end
      ST_BUSY_I: begin
        i_ret_valid = m_ret_valid;
        i_ret_last  = m_ret_last;
        if (m_ret_valid && m_ret_last) state_d = ST_IDLE;
      end
      ST_BUSY_D: begin
        d_ret_valid = m_ret_valid;
        d_ret_last  = m_ret_last;
        if (m_ret_valid && m_ret_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter with an ownership/wait-count reference model.
module tb_cache_mem_arbiter;
  import cache_mem_arbiter_pkg::*;

  localparam int LIM = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_rd_req, d_rd_req, m_rd_rdy, m_ret_valid, m_ret_last;
  logic [2:0]  i_rd_type, d_rd_type;
  logic [31:0] i_rd_addr, d_rd_addr, m_ret_data;
  logic        i_rd_rdy, i_ret_valid, i_ret_last;
  logic        d_rd_rdy, d_ret_valid, d_ret_last;
  logic [31:0] i_ret_data, d_ret_data;
  logic        m_rd_req;
  logic [2:0]  m_rd_type;
  logic [31:0] m_rd_addr;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Model: who currently owns the bridge (0 none, 1 icache, 2 dcache) and
  // how many data grants the waiting icache has watched go by.
  int owner = 0;
  int waits = 0;

  logic [4:0] inst_grants;

  cache_mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .m_rd_req(m_rd_req), .m_rd_type(m_rd_type), .m_rd_addr(m_rd_addr), .m_rd_rdy(m_rd_rdy),
    .m_ret_valid(m_ret_valid), .m_ret_last(m_ret_last), .m_ret_data(m_ret_data)
  );

  always #5 clock = ~clock;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  always @(posedge clock) begin : model_update
    bit want_i, any, hs;
    want_i = i_rd_req && (!d_rd_req || waits == LIM);
    any    = i_rd_req || d_rd_req;
    hs     = any && m_rd_rdy;
    if (reset) begin
      owner = 0;
      waits = 0;
    end else if (owner == 0) begin
      if (hs && want_i) begin
        owner = 1;
        waits = 0;
      end else begin
        if (!i_rd_req) waits = 0;
        else if (hs && waits < LIM) waits = waits + 1;
        if (hs) owner = 2;
      end
    end else if (m_ret_valid && m_ret_last) begin
      owner = 0;
    end
  end

  always @(negedge clock) begin : compare
    bit idle, want_i, any;
    if (chk_en) begin
      idle   = (owner == 0);
      any    = i_rd_req || d_rd_req;
      want_i = i_rd_req && (!d_rd_req || waits == LIM);
      chk1("m_rd_req", m_rd_req, idle && any);
      if (idle && any) begin
        chk32("m_rd_addr", m_rd_addr, want_i ? i_rd_addr : d_rd_addr);
        chk32("m_rd_type", 32'(m_rd_type), 32'(want_i ? i_rd_type : d_rd_type));
      end
      chk1("i_rd_rdy", i_rd_rdy, idle && want_i && m_rd_rdy);
      chk1("d_rd_rdy", d_rd_rdy, idle && d_rd_req && !want_i && m_rd_rdy);
      chk1("i_ret_valid", i_ret_valid, owner == 1 && m_ret_valid);
      chk1("i_ret_last", i_ret_last, owner == 1 && m_ret_last);
      chk1("d_ret_valid", d_ret_valid, owner == 2 && m_ret_valid);
      chk1("d_ret_last", d_ret_last, owner == 2 && m_ret_last);
      chk32("i_ret_data", i_ret_data, m_ret_data);
      chk32("d_ret_data", d_ret_data, m_ret_data);
    end
  end

  initial begin
    reset = 1'b1;
    i_rd_req = 1'b0; i_rd_type = 3'd0; i_rd_addr = 32'd0;
    d_rd_req = 1'b0; d_rd_type = 3'd0; d_rd_addr = 32'd0;
    m_rd_rdy = 1'b0; m_ret_valid = 1'b0; m_ret_last = 1'b0; m_ret_data = 32'd0;
    inst_grants = 5'd0;
    repeat (2) @(posedge clock);
    #1;
    chk_en = 1'b1;
    @(negedge clock);
    chk1("rst_i_rd_rdy", i_rd_rdy, 1'b0);
    chk1("rst_d_rd_rdy", d_rd_rdy, 1'b0);
    chk1("rst_m_rd_req", m_rd_req, 1'b0);
    chk1("rst_i_ret_valid", i_ret_valid, 1'b0);
    chk1("rst_d_ret_last", d_ret_last, 1'b0);
    step();
    reset = 1'b0;

    // Lone icache line read, zero-latency request, four beats to icache only.
    step();
    i_rd_req = 1'b1; i_rd_type = RD_TYPE_LINE; i_rd_addr = 32'h100; m_rd_rdy = 1'b1;
    @(negedge clock);
    chk32("t1_m_rd_addr", m_rd_addr, 32'h100);
    chk32("t1_m_rd_type", 32'(m_rd_type), 32'd4);
    chk1("t1_m_rd_req", m_rd_req, 1'b1);
    chk1("t1_i_rd_rdy", i_rd_rdy, 1'b1);
    step();
    i_rd_req = 1'b0; m_rd_rdy = 1'b0;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) step();
      m_ret_valid = 1'b1; m_ret_last = (b == 3); m_ret_data = 32'hA000 + 32'(b);
      @(negedge clock);
      chk1("t1_i_ret_valid", i_ret_valid, 1'b1);
      chk1("t1_d_ret_valid", d_ret_valid, 1'b0);
      chk1("t1_i_ret_last", i_ret_last, b == 3);
      chk32("t1_i_ret_data", i_ret_data, 32'hA000 + 32'(b));
    end
    step();
    m_ret_valid = 1'b0; m_ret_last = 1'b0;
    @(negedge clock);
    chk1("t1_idle_i_ret_valid", i_ret_valid, 1'b0);

    // Both caches request continuously: four data grants, then the icache.
    i_rd_addr = 32'h200; i_rd_type = RD_TYPE_LINE;
    d_rd_addr = 32'h300; d_rd_type = 3'd0;
    for (int g = 0; g < 5; g++) begin
      step();
      i_rd_req = 1'b1; d_rd_req = 1'b1; m_rd_rdy = 1'b1;
      m_ret_valid = 1'b0; m_ret_last = 1'b0;
      @(negedge clock);
      inst_grants[g] = i_rd_rdy;
      chk1("t2_one_grant", i_rd_rdy ^ d_rd_rdy, 1'b1);
      step();
      m_rd_rdy = 1'b0; m_ret_valid = 1'b1; m_ret_last = 1'b1; m_ret_data = 32'hC0 + 32'(g);
    end
    chk32("t2_grant_order", 32'(inst_grants), 32'b10000);

    // Bridge stalls for three cycles; request must hold and no cache sees rdy.
    step();
    i_rd_req = 1'b0; d_rd_req = 1'b1; d_rd_addr = 32'h400; d_rd_type = RD_TYPE_LINE;
    m_ret_valid = 1'b0; m_ret_last = 1'b0;
    for (int w = 0; w < 4; w++) begin
      if (w > 0) step();
      m_rd_rdy = (w == 3);
      @(negedge clock);
      chk32("t3_m_rd_addr", m_rd_addr, 32'h400);
      chk1("t3_m_rd_req", m_rd_req, 1'b1);
      chk1("t3_d_rd_rdy", d_rd_rdy, w == 3);
      chk1("t3_i_rd_rdy", i_rd_rdy, 1'b0);
    end
    step();
    d_rd_req = 1'b0; m_rd_rdy = 1'b0;
    m_ret_valid = 1'b1; m_ret_last = 1'b1; m_ret_data = 32'hB0;
    @(negedge clock);
    chk1("t3_d_ret_valid", d_ret_valid, 1'b1);
    chk1("t3_d_ret_last", d_ret_last, 1'b1);
    chk1("t3_i_ret_valid", i_ret_valid, 1'b0);

    // A dcache request arriving during an icache read waits for the last beat.
    step();
    m_ret_valid = 1'b0; m_ret_last = 1'b0;
    i_rd_req = 1'b1; i_rd_addr = 32'h500; i_rd_type = 3'd0; m_rd_rdy = 1'b1;
    @(negedge clock);
    chk1("t4_i_rd_rdy", i_rd_rdy, 1'b1);
    step();
    i_rd_req = 1'b0; d_rd_req = 1'b1; d_rd_addr = 32'h600; d_rd_type = 3'd0;
    for (int b = 0; b < 2; b++) begin
      if (b > 0) step();
      m_ret_valid = 1'b1; m_ret_last = (b == 1); m_ret_data = 32'hD0 + 32'(b);
      @(negedge clock);
      chk1("t4_busy_d_rd_rdy", d_rd_rdy, 1'b0);
      chk1("t4_busy_m_rd_req", m_rd_req, 1'b0);
    end
    step();
    m_ret_valid = 1'b0; m_ret_last = 1'b0;
    @(negedge clock);
    chk1("t4_d_rd_rdy", d_rd_rdy, 1'b1);
    chk32("t4_m_rd_addr", m_rd_addr, 32'h600);
    step();
    d_rd_req = 1'b0; m_rd_rdy = 1'b0; m_ret_valid = 1'b1; m_ret_last = 1'b1;

    // Reset taken with the second beat of a line read; later beats are dropped.
    step();
    m_ret_valid = 1'b0; m_ret_last = 1'b0;
    i_rd_req = 1'b1; i_rd_addr = 32'h700; i_rd_type = RD_TYPE_LINE; m_rd_rdy = 1'b1;
    @(negedge clock);
    chk1("t5_i_rd_rdy", i_rd_rdy, 1'b1);
    step();
    i_rd_req = 1'b0; m_rd_rdy = 1'b0; m_ret_valid = 1'b1; m_ret_data = 32'hE0;
    @(negedge clock);
    chk1("t5_beat1_valid", i_ret_valid, 1'b1);
    step();
    reset = 1'b1; m_ret_data = 32'hE1;
    @(negedge clock);
    chk1("t5_beat2_valid", i_ret_valid, 1'b1);
    step();
    reset = 1'b0; m_ret_data = 32'hE2;
    @(negedge clock);
    chk1("t5_beat3_i_valid", i_ret_valid, 1'b0);
    chk1("t5_beat3_d_valid", d_ret_valid, 1'b0);
    step();
    m_ret_last = 1'b1; m_ret_data = 32'hE3;
    @(negedge clock);
    chk1("t5_beat4_i_valid", i_ret_valid, 1'b0);
    chk1("t5_beat4_i_last", i_ret_last, 1'b0);

    // Stray return beat with nothing outstanding.
    step();
    m_ret_valid = 1'b0; m_ret_last = 1'b0;
    step();
    m_ret_valid = 1'b1; m_ret_last = 1'b1; m_ret_data = 32'hF0;
    @(negedge clock);
    chk1("t6_i_ret_valid", i_ret_valid, 1'b0);
    chk1("t6_d_ret_valid", d_ret_valid, 1'b0);
    step();
    m_ret_valid = 1'b0; m_ret_last = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
